// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Time-multiplexed scan controller for a row of DIGITS hex 7-segment digits
// that share one external hex-to-7-segment decoder.
//
// A new display value is loaded into a one-entry pending buffer through a
// valid/ready handshake. At the end of a frame the pending value moves into the
// shadow register, so a frame never shows a mix of old and new digits. In IDLE
// a pending value moves across on the next cycle.
//
// Parameters
//   DIGITS    number of multiplexed digits (2..8)
//   PRESCALE  clock cycles per digit slot (>= 2)
//
// Ports
//   clk         single clock, rising edge
//   reset       synchronous, active-high
//   enable      1 = scan, 0 = idle (all digits off)
//   load_valid  qualifies load_data
//   load_data   display value, nibble k is digit k (digit 0 = LS nibble)
//   load_ready  high while the pending buffer is empty
//   nibble      current digit value to the shared decoder
//   seg_in      active-low segment pattern returned by the decoder
//   seg_out     registered active-low segments to the pins
//   dig_sel     registered active-low digit enables, at most one bit low
//   frame_done  one-cycle pulse after each frame boundary
//
// Configuration
//   SEG7_SCAN_LZB_EN  when defined, leading-zero blanking is enabled: a digit
//                     k>0 whose shadow nibbles k..DIGITS-1 are all zero keeps
//                     its dig_sel bit high. Digit 0 is never blanked.

module seg7_scan_ctrl #(
    parameter int DIGITS   = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  load_valid,
    input  logic [4*DIGITS-1:0]   load_data,
    output logic                  load_ready,
    output logic [3:0]            nibble,
    input  logic [6:0]            seg_in,
    output logic [6:0]            seg_out,
    output logic [DIGITS-1:0]     dig_sel,
    output logic                  frame_done
);

    localparam int PW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IMAX = IW'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } state_t;

    state_t              state;
    logic [PW-1:0]       presc;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] shadow;
    logic [4*DIGITS-1:0] pending;
    logic                pend_full;

    logic                tick;
    logic                boundary;
    logic                accept;
    logic                blank;
    logic                drive;

    assign tick       = (state == SCAN) && (presc == PMAX);
    assign boundary   = tick && (idx == IMAX);
    assign load_ready = !pend_full;
    assign accept     = load_valid && !pend_full;
    assign nibble     = shadow[{idx, 2'b00} +: 4];

`ifdef SEG7_SCAN_LZB_EN
    // Blank when this digit and every more significant digit are zero.
    always_comb begin
        blank = 1'b0;
        if ((idx != '0) && ((shadow >> {idx, 2'b00}) == '0)) begin
            blank = 1'b1;
        end
    end
`else
    assign blank = 1'b0;
`endif

    // Dropping enable turns the digits off on the very next edge, together
    // with the move to IDLE.
    assign drive = (state == SCAN) && enable && !blank;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            presc      <= '0;
            idx        <= '0;
            shadow     <= '0;
            pend_full  <= 1'b0;
            seg_out    <= 7'h7F;
            dig_sel    <= '1;
            frame_done <= 1'b0;
        end else begin
            frame_done <= boundary;
            seg_out    <= drive ? seg_in : 7'h7F;
            dig_sel    <= drive ? ~(DIGITS'(1) << idx) : '1;

            // Transfer and accept are exclusive: accept needs an empty buffer,
            // transfer needs a full one, so a load taken on a boundary cycle
            // waits for the following boundary.
            if (pend_full && (boundary || (state == IDLE))) begin
                shadow    <= pending;
                pend_full <= 1'b0;
            end else if (accept) begin
                pending   <= load_data;
                pend_full <= 1'b1;
            end

            case (state)
                IDLE: begin
                    presc <= '0;
                    idx   <= '0;
                    if (enable) begin
                        state <= SCAN;
                    end
                end
                SCAN: begin
                    if (!enable) begin
                        state <= IDLE;
                        presc <= '0;
                        idx   <= '0;
                    end else if (tick) begin
                        presc <= '0;
                        idx   <= (idx == IMAX) ? '0 : idx + 1'b1;
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    presc <= '0;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl
// Scoreboard bench for seg7_scan_ctrl with DIGITS=8, PRESCALE=4. A reference
// model tracks time since scan start, the shadow value and the pending buffer,
// and pushes the expected registered outputs each cycle; a monitor pops and
// compares on the falling edge. The bench also plays the external decoder.

module tb_seg7_scan_ctrl;

    localparam int D  = 8;
    localparam int P  = 4;
    localparam int FR = D * P;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        load_valid = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_ready;
    logic [3:0]  nibble;
    logic [6:0]  seg_in;
    logic [6:0]  seg_out;
    logic [7:0]  dig_sel;
    logic        frame_done;

    always #5 clk = ~clk;

    function automatic logic [6:0] dec7(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;  4'h1: return 7'h79;
            4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;
            4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;
            4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;
            4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    assign seg_in = dec7(nibble);

    seg7_scan_ctrl #(.DIGITS(D), .PRESCALE(P)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .nibble     (nibble),
        .seg_in     (seg_in),
        .seg_out    (seg_out),
        .dig_sel    (dig_sel),
        .frame_done (frame_done)
    );

    typedef struct packed {
        logic [7:0] dig;
        logic [6:0] seg;
        logic       fd;
        logic       rdy;
        logic [3:0] nib;
    } obs_t;

    obs_t        expq[$];
    int          vectors = 0;
    int          miscompares = 0;

    // Reference state: m_t counts cycles since scan start, modulo one frame.
    bit          m_scan = 1'b0;
    int          m_t = 0;
    logic [31:0] m_shadow = '0;
    logic [31:0] m_pend = '0;
    bit          m_full = 1'b0;

    function automatic bit blanked(input logic [31:0] v, input int k);
`ifdef SEG7_SCAN_LZB_EN
        int sig;
        sig = 1;
        for (int j = 0; j < D; j++) begin
            if (v[4*j +: 4] != 4'h0) sig = j + 1;
        end
        return (k >= sig);
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk) begin
        obs_t e;
        int   ci;
        bit   bnd;
        if (reset) begin
            m_scan   = 1'b0;
            m_t      = 0;
            m_shadow = '0;
            m_full   = 1'b0;
            e.dig    = 8'hFF;
            e.seg    = 7'h7F;
            e.fd     = 1'b0;
        end else begin
            ci  = m_scan ? (m_t / P) % D : 0;
            bnd = m_scan && (m_t == FR - 1);
            if (m_scan && enable && !blanked(m_shadow, ci)) begin
                e.dig = ~(8'h01 << ci);
                e.seg = dec7(m_shadow[4*ci +: 4]);
            end else begin
                e.dig = 8'hFF;
                e.seg = 7'h7F;
            end
            e.fd = bnd;
            if (m_full && (bnd || !m_scan)) begin
                m_shadow = m_pend;
                m_full   = 1'b0;
            end else if (!m_full && load_valid) begin
                m_pend = load_data;
                m_full = 1'b1;
            end
            if (m_scan) begin
                if (enable) begin
                    m_t = (m_t + 1) % FR;
                end else begin
                    m_scan = 1'b0;
                    m_t    = 0;
                end
            end else if (enable) begin
                m_scan = 1'b1;
                m_t    = 0;
            end
        end
        e.rdy = !m_full;
        ci    = m_scan ? (m_t / P) % D : 0;
        e.nib = m_shadow[4*ci +: 4];
        expq.push_back(e);
    end

    always @(negedge clk) begin
        obs_t e;
        obs_t a;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            a = {dig_sel, seg_out, frame_done, load_ready, nibble};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t dig_sel/seg_out/frame_done/load_ready/nibble got %h/%h/%b/%b/%h expected %h/%h/%b/%b/%h",
                         $time, a.dig, a.seg, a.fd, a.rdy, a.nib,
                         e.dig, e.seg, e.fd, e.rdy, e.nib);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Returns on the falling edge where the model sits at scan time 'target'.
    task automatic wait_t(input int target);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (m_scan && (m_t == target)) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL wait_t scan time got %0d expected %0d", m_t, target);
        end
    endtask

    task automatic load(input logic [31:0] v);
        load_valid = 1'b1;
        load_data  = v;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        cyc(3);
        reset = 1'b0;
        cyc(2);
        enable = 1'b1;
        cyc(70);

        // Mid-frame load, then a held load_valid that must be ignored.
        wait_t(10);
        load(32'h1234_5678);
        load_valid = 1'b1;
        load_data  = 32'hFFFF_0000;
        cyc(3);
        load_valid = 1'b0;
        cyc(70);

        // Load on the boundary cycle shows only after the following boundary.
        wait_t(FR - 1);
        load(32'hCAFE_BABE);
        cyc(80);

        // Drop enable while digit 5 is displayed, then restart.
        wait_t(5 * P + 1);
        enable = 1'b0;
        cyc(3);
        enable = 1'b1;
        cyc(40);

        load(32'h0000_00A0);
        cyc(70);
        load(32'h0000_0000);
        cyc(70);

        // Reset with a full pending buffer: that value is never shown.
        wait_t(12);
        load(32'hDEAD_BEEF);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        cyc(70);

        for (int i = 0; i < 1500; i++) begin
            enable     = ($urandom_range(0, 99) < 95);
            load_valid = ($urandom_range(0, 99) < 20);
            load_data  = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
            @(negedge clk);
        end
        reset      = 1'b0;
        load_valid = 1'b0;
        enable     = 1'b1;
        cyc(4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
